// File: rtl/spi_target_regs.sv
// SPI target with a small 8-bit register file, clocked entirely from pclk_i.
// Optional build macro SPI_TARGET_MSB_FIRST_EN: shift address/data MSB first (default LSB first).
module spi_target_regs #(
    parameter int REG_DEPTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       pclk_i,
    input  logic       prst_i,
    input  logic       sclk_i,
    input  logic       mosi_i,
    input  logic       cs_i,
    output logic       miso_o,
    input  logic [3:0] rd_addr_i,
    output logic [7:0] rd_data_o,
    output logic       wr_pulse_o,
    output logic [3:0] wr_addr_o,
    output logic [7:0] wr_data_o,
    output logic       err_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        DATA_WR = 3'd2,
        DATA_RD = 3'd3,
        COMMIT  = 3'd4
    } state_t;

    localparam logic [7:0] DEPTH8 = 8'(REG_DEPTH);

    // Handshake: there is none; every detected sclk rise while selected consumes one bit.
    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
    logic                   sclk_dly;
    logic                   sclk_s, mosi_s, cs_s, rise;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [6:0]  addr_q;
    logic [7:0]  rd_shift;
    logic [7:0]  regs [REG_DEPTH];

    logic [7:0]  shift_next;
    logic        last_bit;
    logic        in_range_next, in_range_q;
    logic        commit_wr, commit_err, abort_err;
    logic [7:0]  rd_lookup;

    function automatic logic [7:0] shift_in(input logic [7:0] sh, input logic b);
`ifdef SPI_TARGET_MSB_FIRST_EN
        return {sh[6:0], b};
`else
        return {b, sh[7:1]};
`endif
    endfunction

    function automatic logic [7:0] shift_out(input logic [7:0] sh);
`ifdef SPI_TARGET_MSB_FIRST_EN
        return {sh[6:0], 1'b1};
`else
        return {1'b1, sh[7:1]};
`endif
    endfunction

    always_ff @(posedge pclk_i) begin
        if (!prst_i) begin
            sclk_sync <= '1;
            mosi_sync <= '0;
            cs_sync   <= '0;
            sclk_dly  <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_i};
            sclk_dly  <= sclk_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_dly;

    assign shift_next    = shift_in(shreg, mosi_s);
    assign last_bit      = rise && (bit_cnt == 3'd7);
    assign in_range_next = {1'b0, shift_next[6:0]} < DEPTH8;
    assign in_range_q    = {1'b0, addr_q} < DEPTH8;
    assign rd_lookup     = ({4'b0, rd_addr_i} < DEPTH8) ? regs[rd_addr_i] : 8'hFF;

    always_ff @(posedge pclk_i) begin
        if (!prst_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        commit_wr  = 1'b0;
        commit_err = 1'b0;
        abort_err  = 1'b0;
        case (state_q)
            IDLE:    if (cs_s) state_d = ADDR;
            ADDR:    if (last_bit) state_d = shift_next[7] ? DATA_WR : DATA_RD;
            DATA_WR: if (last_bit) state_d = COMMIT;
            DATA_RD: if (last_bit) state_d = ADDR;
            COMMIT: begin
                state_d    = ADDR;
                commit_wr  = in_range_q;
                commit_err = ~in_range_q;
            end
            default: state_d = IDLE;
        endcase
        // Deselect wins over everything, including a pending commit.
        if (state_q != IDLE && !cs_s) begin
            state_d    = IDLE;
            commit_wr  = 1'b0;
            commit_err = 1'b0;
            abort_err  = (bit_cnt != 3'd0);
        end
    end

    always_ff @(posedge pclk_i) begin
        if (!prst_i) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            addr_q     <= '0;
            rd_shift   <= '0;
            rd_data_o  <= '0;
            wr_pulse_o <= 1'b0;
            wr_addr_o  <= '0;
            wr_data_o  <= '0;
            err_o      <= 1'b0;
            for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
        end else begin
            wr_pulse_o <= commit_wr;
            err_o      <= commit_err | abort_err;
            rd_data_o  <= rd_lookup;

            if (state_q == IDLE || state_d == IDLE) begin
                bit_cnt <= '0;
            end else if (rise && (state_q == ADDR || state_q == DATA_WR || state_q == DATA_RD)) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (state_q != DATA_RD) shreg <= shift_next;
                if (state_q == DATA_RD) rd_shift <= shift_out(rd_shift);
                if (state_q == ADDR && last_bit) begin
                    addr_q <= shift_next[6:0];
                    if (!shift_next[7])
                        rd_shift <= in_range_next ? regs[shift_next[3:0]] : 8'hFF;
                end
            end

            if (commit_wr) begin
                regs[addr_q[3:0]] <= shreg;
                wr_addr_o         <= addr_q[3:0];
                wr_data_o         <= shreg;
            end
        end
    end

`ifdef SPI_TARGET_MSB_FIRST_EN
    assign miso_o = (state_q == DATA_RD) ? rd_shift[7] : 1'b1;
`else
    assign miso_o = (state_q == DATA_RD) ? rd_shift[0] : 1'b1;
`endif

    assign state_o = state_q;

endmodule

// File: tb/tb_spi_target_regs.sv
// Directed bench for spi_target_regs: transaction table plus abort and reset corner sequences.
module tb_spi_target_regs;

    logic       pclk_i = 1'b0;
    logic       prst_i = 1'b0;
    logic       sclk_i = 1'b1;
    logic       mosi_i = 1'b0;
    logic       cs_i   = 1'b0;
    logic       miso_o;
    logic [3:0] rd_addr_i = '0;
    logic [7:0] rd_data_o;
    logic       wr_pulse_o;
    logic [3:0] wr_addr_o;
    logic [7:0] wr_data_o;
    logic       err_o;
    logic [2:0] state_o;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;
    int err_cnt  = 0;
    logic [7:0] model [16];

    spi_target_regs dut (
        .pclk_i    (pclk_i),
        .prst_i    (prst_i),
        .sclk_i    (sclk_i),
        .mosi_i    (mosi_i),
        .cs_i      (cs_i),
        .miso_o    (miso_o),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (rd_data_o),
        .wr_pulse_o(wr_pulse_o),
        .wr_addr_o (wr_addr_o),
        .wr_data_o (wr_data_o),
        .err_o     (err_o),
        .state_o   (state_o)
    );

    // clock / reset
    always #5 pclk_i = ~pclk_i;

    // strobe counters: a stuck strobe counts once per cycle it stays high
    always @(negedge pclk_i) begin
        if (prst_i) begin
            if (wr_pulse_o) wr_cnt++;
            if (err_o)      err_cnt++;
        end
    end

    typedef struct {
        logic       is_wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_miso;
        int         exp_wr;
        int         exp_err;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int bit_idx(input int i);
`ifdef SPI_TARGET_MSB_FIRST_EN
        return 7 - i;
`else
        return i;
`endif
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge pclk_i);
    endtask

    // driver: mode-3 style, data changes with the falling sclk, sampled on the rise
    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            sclk_i = 1'b0;
            mosi_i = b[bit_idx(i)];
            wait_clks(4);
            sclk_i = 1'b1;
            wait_clks(4);
        end
    endtask

    task automatic recv_byte(output logic [7:0] b);
        b = '0;
        for (int i = 0; i < 8; i++) begin
            sclk_i = 1'b0;
            mosi_i = 1'b0;
            wait_clks(4);
            b[bit_idx(i)] = miso_o;
            sclk_i = 1'b1;
            wait_clks(4);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int a = 0; a < 16; a++) begin
            rd_addr_i = 4'(a);
            wait_clks(1);
            check($sformatf("%s_rd%0d", tag, a), 32'(rd_data_o), 32'(model[a]));
        end
    endtask

    initial begin
        int         wr0, err0;
        logic [7:0] rx;

        vecs[0]  = '{1'b1, 8'h83, 8'hA5, 8'h00, 1, 0};
        vecs[1]  = '{1'b0, 8'h03, 8'h00, 8'hA5, 0, 0};
        vecs[2]  = '{1'b1, 8'h9F, 8'h11, 8'h00, 0, 1};
        vecs[3]  = '{1'b0, 8'h1F, 8'h00, 8'hFF, 0, 0};
        vecs[4]  = '{1'b1, 8'h80, 8'h01, 8'h00, 1, 0};
        vecs[5]  = '{1'b1, 8'h81, 8'h02, 8'h00, 1, 0};
        vecs[6]  = '{1'b0, 8'h00, 8'h00, 8'h01, 0, 0};
        vecs[7]  = '{1'b0, 8'h01, 8'h00, 8'h02, 0, 0};
        vecs[8]  = '{1'b0, 8'h03, 8'h00, 8'hA5, 0, 0};
        vecs[9]  = '{1'b1, 8'h8F, 8'h3C, 8'h00, 1, 0};
        vecs[10] = '{1'b0, 8'h0F, 8'h00, 8'h3C, 0, 0};
        vecs[11] = '{1'b0, 8'h10, 8'h00, 8'hFF, 0, 0};
        vecs[12] = '{1'b1, 8'h90, 8'h77, 8'h00, 0, 1};
        for (int a = 0; a < 16; a++) model[a] = 8'h00;

        // reset state
        wait_clks(4);
        check("rst_state",  32'(state_o),    32'(ST_IDLE));
        check("rst_miso",   32'(miso_o),     32'h1);
        check("rst_rddata", 32'(rd_data_o),  32'h0);
        check("rst_wrpls",  32'(wr_pulse_o), 32'h0);
        check("rst_wraddr", 32'(wr_addr_o),  32'h0);
        check("rst_wrdata", 32'(wr_data_o),  32'h0);
        check("rst_err",    32'(err_o),      32'h0);
        prst_i = 1'b1;
        wait_clks(2);
        cs_i = 1'b1;
        wait_clks(6);
        check("sel_state", 32'(state_o), 32'(ST_ADDR));

        // transaction table, cs held high throughout, 4 gap clocks between phases
        for (int v = 0; v < 13; v++) begin
            wr0  = wr_cnt;
            err0 = err_cnt;
            send_bits(vecs[v].addr, 8);
            wait_clks(4);
            if (vecs[v].is_wr) begin
                send_bits(vecs[v].data, 8);
                wait_clks(8);
                check($sformatf("v%0d_miso_idle", v), 32'(miso_o), 32'h1);
                if (vecs[v].exp_wr == 1) begin
                    model[vecs[v].addr[3:0]] = vecs[v].data;
                    check($sformatf("v%0d_wraddr", v), 32'(wr_addr_o), 32'(vecs[v].addr[3:0]));
                    check($sformatf("v%0d_wrdata", v), 32'(wr_data_o), 32'(vecs[v].data));
                end
            end else begin
                recv_byte(rx);
                wait_clks(4);
                check($sformatf("v%0d_miso", v), 32'(rx), 32'(vecs[v].exp_miso));
            end
            check($sformatf("v%0d_wrcnt", v),  32'(wr_cnt - wr0),   32'(vecs[v].exp_wr));
            check($sformatf("v%0d_errcnt", v), 32'(err_cnt - err0), 32'(vecs[v].exp_err));
            check($sformatf("v%0d_state", v),  32'(state_o),        32'(ST_ADDR));
        end
        check_regs("tbl");

        // deselect with no partial bits: quiet return to idle
        err0 = err_cnt;
        cs_i = 1'b0;
        wait_clks(6);
        check("desel_state", 32'(state_o),        32'(ST_IDLE));
        check("desel_err",   32'(err_cnt - err0), 32'h0);

        // abort after 5 data bits of a write to addr 2
        wr0  = wr_cnt;
        err0 = err_cnt;
        cs_i = 1'b1;
        wait_clks(6);
        send_bits(8'h82, 8);
        wait_clks(4);
        send_bits(8'hEE, 5);
        cs_i = 1'b0;
        wait_clks(8);
        check("abort_err",   32'(err_cnt - err0), 32'h1);
        check("abort_wr",    32'(wr_cnt - wr0),   32'h0);
        check("abort_state", 32'(state_o),        32'(ST_IDLE));
        rd_addr_i = 4'd2;
        wait_clks(1);
        check("abort_reg2", 32'(rd_data_o), 32'(model[2]));

        // reset during the data phase of a write to addr 4
        wr0  = wr_cnt;
        err0 = err_cnt;
        cs_i = 1'b1;
        wait_clks(6);
        send_bits(8'h84, 8);
        wait_clks(4);
        send_bits(8'h5A, 4);
        prst_i = 1'b0;
        cs_i   = 1'b0;
        wait_clks(3);
        prst_i = 1'b1;
        for (int a = 0; a < 16; a++) model[a] = 8'h00;
        wait_clks(1);
        check("mrst_state",  32'(state_o),        32'(ST_IDLE));
        check("mrst_miso",   32'(miso_o),         32'h1);
        check("mrst_wraddr", 32'(wr_addr_o),      32'h0);
        check("mrst_wrdata", 32'(wr_data_o),      32'h0);
        check("mrst_wr",     32'(wr_cnt - wr0),   32'h0);
        check("mrst_err",    32'(err_cnt - err0), 32'h0);
        check_regs("mrst");

        // write after reset
        wr0 = wr_cnt;
        cs_i = 1'b1;
        wait_clks(6);
        send_bits(8'h84, 8);
        wait_clks(4);
        send_bits(8'h5A, 8);
        wait_clks(8);
        model[4] = 8'h5A;
        check("post_wr",     32'(wr_cnt - wr0), 32'h1);
        check("post_wraddr", 32'(wr_addr_o),    32'h4);
        check("post_wrdata", 32'(wr_data_o),    32'h5A);
        check_regs("post");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_target_regs.md
SPI_TARGET_REGS -- requirements
Module: spi_target_regs

Interface
REQ-001 SHALL have parameter REG_DEPTH, default 16: number of 8-bit target registers, addressed by addr[3:0].
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth on sclk_i, mosi_i and cs_i.
REQ-003 SHALL have port pclk_i, input, 1 bit: the only clock.
REQ-004 SHALL have port prst_i, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port sclk_i, input, 1 bit: SPI clock from the controller, idles high, asynchronous to pclk_i.
REQ-006 SHALL have port mosi_i, input, 1 bit: serial data from the controller.
REQ-007 SHALL have port cs_i, input, 1 bit: target select, active high.
REQ-008 SHALL have port miso_o, output, 1 bit: serial read data to the controller.
REQ-009 SHALL have port rd_addr_i, input, 4 bits: local read address.
REQ-010 SHALL have port rd_data_o, output, 8 bits: registered local read data.
REQ-011 SHALL have port wr_pulse_o, output, 1 bit: one-cycle strobe on each SPI write commit.
REQ-012 SHALL have port wr_addr_o, output, 4 bits: address of the last commit.
REQ-013 SHALL have port wr_data_o, output, 8 bits: data of the last commit.
REQ-014 SHALL have port err_o, output, 1 bit: one-cycle strobe on an aborted or out-of-range transaction.

Function
REQ-015 SHALL pass sclk_i, mosi_i and cs_i through SYNC_STAGES flops, then detect sclk edges from the synchronised value and one extra delayed copy; pclk_i SHALL run at least 4x sclk_i.
REQ-016 SHALL implement the states IDLE, ADDR, DATA_WR, DATA_RD and COMMIT.
REQ-017 IDLE -> ADDR when synchronised cs_i=1; bit counter cleared.
REQ-018 ADDR SHALL sample mosi on each detected sclk rise into an 8-bit shift register, LSB first.
REQ-019 After the 8th address rise, ADDR SHALL go to DATA_WR if addr[7]=1, else to DATA_RD.
REQ-020 On entry to DATA_RD, the block SHALL load the read shift register with reg[addr[3:0]], or 8'hFF if addr[6:0] >= REG_DEPTH.
REQ-021 miso_o SHALL present read-shift bit 0 from the cycle of DATA_RD entry.
REQ-022 In DATA_RD, miso_o SHALL advance one bit 1 pclk after each detected rise.
REQ-023 DATA_WR SHALL sample 8 mosi bits on detected rises, LSB first.
REQ-024 After the 8th data rise, DATA_WR SHALL go to COMMIT and DATA_RD SHALL go to ADDR.
REQ-025 COMMIT SHALL last one cycle; if addr[6:0] < REG_DEPTH it SHALL write the register and pulse wr_pulse_o with wr_addr_o/wr_data_o updated, otherwise it SHALL pulse err_o only; then go to ADDR.
REQ-026 Sclk-high gaps between address and data, or between transactions, SHALL produce no edges and cause no state change.
REQ-027 Synchronised cs_i falling to 0 in any non-IDLE state SHALL go to IDLE, discard partial bits, write nothing, and pulse err_o if the bit counter is nonzero.
REQ-028 miso_o SHALL be 1 whenever the state is not DATA_RD.
REQ-029 rd_data_o SHALL equal reg[rd_addr_i] registered 1 cycle later; on a same-cycle COMMIT to the same address it SHALL return the old value.

Reset
REQ-030 While prst_i=0 at a pclk_i rise: state=IDLE, all registers 0, synchronisers 1 for sclk and 0 for cs/mosi, miso_o=1, rd_data_o=0, wr_pulse_o=0, wr_addr_o=0, wr_data_o=0, err_o=0.
REQ-031 Reset asserted mid-transaction SHALL abandon it with no register write and no err_o pulse.

Configuration
REQ-032 With SPI_TARGET_MSB_FIRST_EN defined, address and data bits SHALL shift MSB first on both mosi and miso.
REQ-033 Without SPI_TARGET_MSB_FIRST_EN, all shifting SHALL be LSB first.

Verification
REQ-034 Reset, cs=1, addr 8'h83, 4 gap clocks, data 8'hA5 -> wr_pulse_o once, wr_addr_o=3, wr_data_o=8'hA5; rd_addr_i=3 gives rd_data_o=8'hA5 next cycle.
REQ-035 After REQ-034, addr 8'h03 then 8 data clocks -> miso_o bit sequence 1,0,1,0,0,1,0,1 (LSB first).
REQ-036 Addr 8'h9F with data 8'h11 -> err_o one pulse, no wr_pulse_o, all registers unchanged; read at addr 8'h1F -> miso_o all ones.
REQ-037 cs_i dropped after 5 data bits of a write to addr 2 -> err_o pulse, reg[2] unchanged, state IDLE.
REQ-038 Back-to-back writes 8'h80/8'h01 and 8'h81/8'h02 separated by 4 gap clocks -> two wr_pulse_o, reg[0]=1, reg[1]=2.
REQ-039 prst_i=0 during the data phase, then released -> all outputs at reset values and a following write succeeds.
